// File: rtl/bus_gate_mux.sv
// Registered one-hot gated bus multiplexer with conflict detection, policy and diagnostics.
// One cycle of latency; no handshake, gate and source data are sampled together every cycle.
module bus_gate_mux #(
  parameter int WIDTH           = 16,
  parameter int N               = 4,
  parameter int CONFLICT_POLICY = 0,
  parameter int HOLD_IDLE       = 0,
  parameter int CNT_W           = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N-1:0]       gate,
  input  logic [N*WIDTH-1:0] src_data,
  input  logic               clr_diag,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic               conflict,
  output logic               conflict_sticky,
  output logic [N-1:0]       conflict_mask,
  output logic [CNT_W-1:0]   conflict_cnt
);

  typedef enum logic {CLEAN, FAULTED} diag_e;

  diag_e            state_q, state_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic             conflict_q, conflict_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_gate;
  logic             multi_gate;
  logic [WIDTH-1:0] low_sel;

  // Clearing the lowest set bit leaves something only when two or more gates are set.
  always_comb begin
    any_gate   = |gate;
    multi_gate = |(gate & (gate - N'(1)));
    low_sel    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gate[i]) low_sel = src_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus_d      = '0;
    valid_d    = any_gate & ~multi_gate;
    conflict_d = multi_gate;
    if (multi_gate) begin
      bus_d = (CONFLICT_POLICY == 1) ? low_sel : '1;
    end else if (any_gate) begin
      bus_d = low_sel;
    end else if (HOLD_IDLE == 1) begin
      bus_d = bus_q;
    end
  end

  // Clear beats a same-cycle conflict; the mask keeps only the first conflict after a clear.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (clr_diag) begin
      state_d = CLEAN;
      mask_d  = '0;
      cnt_d   = '0;
    end else if (multi_gate) begin
      if (state_q == CLEAN) begin
        state_d = FAULTED;
        mask_d  = gate;
      end
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= CLEAN;
      bus_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      mask_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_out         = bus_q;
  assign bus_valid       = valid_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = (state_q == FAULTED);
  assign conflict_mask   = mask_q;
  assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_gate_mux.sv
// Directed bench for bus_gate_mux: three instances cover policy 0/hold 0, policy 1/hold 1/2-bit counter, and N=8 WIDTH=32.
module tb_bus_gate_mux;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        clr_diag;
  logic [3:0]  gate;
  logic [63:0] src_data;
  logic [7:0]  gate8;
  logic [255:0] src8;

  logic [15:0] a_bus;  logic a_vld, a_cf, a_st;  logic [3:0] a_mask;  logic [7:0] a_cnt;
  logic [15:0] b_bus;  logic b_vld, b_cf, b_st;  logic [3:0] b_mask;  logic [1:0] b_cnt;
  logic [31:0] c_bus;  logic c_vld, c_cf, c_st;  logic [7:0] c_mask;  logic [7:0] c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  bus_gate_mux #(.WIDTH(16), .N(4), .CONFLICT_POLICY(0), .HOLD_IDLE(0), .CNT_W(8)) u_a (
    .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src_data), .clr_diag(clr_diag),
    .bus_out(a_bus), .bus_valid(a_vld), .conflict(a_cf), .conflict_sticky(a_st),
    .conflict_mask(a_mask), .conflict_cnt(a_cnt));

  bus_gate_mux #(.WIDTH(16), .N(4), .CONFLICT_POLICY(1), .HOLD_IDLE(1), .CNT_W(2)) u_b (
    .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src_data), .clr_diag(clr_diag),
    .bus_out(b_bus), .bus_valid(b_vld), .conflict(b_cf), .conflict_sticky(b_st),
    .conflict_mask(b_mask), .conflict_cnt(b_cnt));

  bus_gate_mux #(.WIDTH(32), .N(8), .CONFLICT_POLICY(0), .HOLD_IDLE(0), .CNT_W(8)) u_c (
    .Clk(Clk), .Reset(Reset), .gate(gate8), .src_data(src8), .clr_diag(clr_diag),
    .bus_out(c_bus), .bus_valid(c_vld), .conflict(c_cf), .conflict_sticky(c_st),
    .conflict_mask(c_mask), .conflict_cnt(c_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1 time unit after an edge; one step = next rising edge, then sample 1 unit later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset    = 1'b1;
    clr_diag = 1'b0;
    gate     = 4'b0000;
    src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    gate8    = 8'h00;
    src8     = {32'hDEADBEEF, 32'h77777777, 32'h66666666, 32'h55555555,
                32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    #2;
    step();

    check("rst_bus",    {48'd0, a_bus}, 64'h0);
    check("rst_valid",  {63'd0, a_vld}, 64'h0);
    check("rst_conf",   {63'd0, a_cf},  64'h0);
    check("rst_sticky", {63'd0, a_st},  64'h0);
    check("rst_mask",   {60'd0, a_mask}, 64'h0);
    check("rst_cnt",    {56'd0, a_cnt}, 64'h0);
    check("rst_c_bus",  {32'd0, c_bus}, 64'h0);

    Reset = 1'b0;
    step();
    check("hold_after_rst", {48'd0, b_bus}, 64'h0);

    // Single-gate sweep
    for (int i = 0; i < 4; i++) begin
      gate = 4'b0001 << i;
      step();
      check("sweep_bus",   {48'd0, a_bus}, 64'h1111 * (i + 1));
      check("sweep_valid", {63'd0, a_vld}, 64'h1);
      check("sweep_conf",  {63'd0, a_cf},  64'h0);
      check("sweep_b_bus", {48'd0, b_bus}, 64'h1111 * (i + 1));
    end

    // Idle behaviour after driving 0x3333
    gate = 4'b0100;
    step();
    gate = 4'b0000;
    step();
    check("idle_a_bus",   {48'd0, a_bus}, 64'h0);
    check("idle_a_valid", {63'd0, a_vld}, 64'h0);
    check("idle_b_hold",  {48'd0, b_bus}, 64'h3333);
    check("idle_b_valid", {63'd0, b_vld}, 64'h0);

    // First conflict
    gate = 4'b0110;
    step();
    check("cf_a_bus",    {48'd0, a_bus}, 64'hFFFF);
    check("cf_b_bus",    {48'd0, b_bus}, 64'h2222);
    check("cf_a_valid",  {63'd0, a_vld}, 64'h0);
    check("cf_b_valid",  {63'd0, b_vld}, 64'h0);
    check("cf_a_conf",   {63'd0, a_cf},  64'h1);
    check("cf_b_conf",   {63'd0, b_cf},  64'h1);
    check("cf_a_sticky", {63'd0, a_st},  64'h1);
    check("cf_a_mask",   {60'd0, a_mask}, 64'h6);
    check("cf_b_mask",   {60'd0, b_mask}, 64'h6);
    check("cf_a_cnt",    {56'd0, a_cnt}, 64'h1);

    gate = 4'b0000;
    step();
    check("cf_pulse_end", {63'd0, a_cf}, 64'h0);
    check("cf_sticky_hold", {63'd0, a_st}, 64'h1);

    // Second conflict must not overwrite the mask
    gate = 4'b1001;
    step();
    check("cf2_a_mask", {60'd0, a_mask}, 64'h6);
    check("cf2_a_cnt",  {56'd0, a_cnt}, 64'h2);
    check("cf2_b_bus",  {48'd0, b_bus}, 64'h1111);
    check("cf2_b_cnt",  {62'd0, b_cnt}, 64'h2);

    // Three more conflicts: 2-bit counter saturates at 3
    gate = 4'b0011;
    for (int i = 0; i < 3; i++) step();
    check("sat_b_cnt", {62'd0, b_cnt}, 64'h3);
    check("sat_a_cnt", {56'd0, a_cnt}, 64'h5);

    // Clear together with a conflict
    clr_diag = 1'b1;
    gate     = 4'b0110;
    step();
    check("clr_a_sticky", {63'd0, a_st},  64'h0);
    check("clr_a_mask",   {60'd0, a_mask}, 64'h0);
    check("clr_a_cnt",    {56'd0, a_cnt}, 64'h0);
    check("clr_a_conf",   {63'd0, a_cf},  64'h1);
    check("clr_b_cnt",    {62'd0, b_cnt}, 64'h0);
    clr_diag = 1'b0;
    gate     = 4'b0000;
    step();
    check("post_clr_sticky", {63'd0, a_st}, 64'h0);

    // Reset mid-operation
    gate = 4'b1000;
    step();
    gate = 4'b0110;
    step();
    Reset = 1'b1;
    gate  = 4'b0001;
    step();
    check("mid_rst_bus",    {48'd0, a_bus}, 64'h0);
    check("mid_rst_valid",  {63'd0, a_vld}, 64'h0);
    check("mid_rst_conf",   {63'd0, a_cf},  64'h0);
    check("mid_rst_sticky", {63'd0, a_st},  64'h0);
    check("mid_rst_cnt",    {56'd0, a_cnt}, 64'h0);
    check("mid_rst_b_bus",  {48'd0, b_bus}, 64'h0);
    Reset = 1'b0;
    step();
    check("after_rst_bus",   {48'd0, a_bus}, 64'h1111);
    check("after_rst_valid", {63'd0, a_vld}, 64'h1);

    // Wide variant: N=8, WIDTH=32
    gate8 = 8'b1000_0000;
    step();
    check("wide_bus",   {32'd0, c_bus}, 64'hDEADBEEF);
    check("wide_valid", {63'd0, c_vld}, 64'h1);
    gate8 = 8'b0000_0100;
    step();
    check("wide_bus2",  {32'd0, c_bus}, 64'h33333333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
